// File: rtl/tetris_pkg.sv
// Shared board geometry, coordinate types and checker FSM states for the
// tetromino collision checker.
package tetris_pkg;

  localparam int BOARD_COLS_DEF = 10;
  localparam int BOARD_ROWS_DEF = 20;
  localparam int COORD_W        = 5;
  localparam int OFF_W          = 5;
  localparam int ABS_W          = COORD_W + 2;

  typedef logic signed [OFF_W-1:0] offset_t;
  typedef logic signed [ABS_W-1:0] abs_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_READ1,
    ST_READ2,
    ST_READ3,
    ST_READ4,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tetron_abs_coord.sv
// Combinational origin+offset adder for one block, with bounds and
// above-the-top (spawn zone) classification.
module tetron_abs_coord
  import tetris_pkg::*;
#(
  parameter int BOARD_COLS = BOARD_COLS_DEF,
  parameter int BOARD_ROWS = BOARD_ROWS_DEF
) (
  input  logic [COORD_W-1:0] origin_row,
  input  logic [COORD_W-1:0] origin_col,
  input  logic [OFF_W-1:0]   voff,
  input  logic [OFF_W-1:0]   hoff,
  output logic [COORD_W-1:0] cell_row,
  output logic [COORD_W-1:0] cell_col,
  output logic               oob,
  output logic               above
);

  localparam abs_t COLS_S = abs_t'(BOARD_COLS);
  localparam abs_t ROWS_S = abs_t'(BOARD_ROWS);

  abs_t row_s;
  abs_t col_s;

  always_comb begin
    row_s = $signed({2'b00, origin_row}) + $signed({{(ABS_W-OFF_W){voff[OFF_W-1]}}, voff});
    col_s = $signed({2'b00, origin_col}) + $signed({{(ABS_W-OFF_W){hoff[OFF_W-1]}}, hoff});
    // Negative rows are the spawn zone: legal, never read.
    oob      = col_s[ABS_W-1] | (col_s >= COLS_S) | (row_s >= ROWS_S);
    above    = row_s[ABS_W-1];
    cell_row = row_s[COORD_W-1:0];
    cell_col = col_s[COORD_W-1:0];
  end

endmodule

// File: rtl/tetron_collision_checker.sv
// Checks a candidate tetromino placement against board bounds and the
// occupancy RAM. Optional early exit: define TETRON_CC_EARLY_EXIT_EN.
module tetron_collision_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_COLS = BOARD_COLS_DEF,
  parameter int BOARD_ROWS = BOARD_ROWS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [COORD_W-1:0] origin_row,
  input  logic [COORD_W-1:0] origin_col,
  input  logic [4:0]         blk1_voffset,
  input  logic [4:0]         blk2_voffset,
  input  logic [4:0]         blk3_voffset,
  input  logic [4:0]         blk4_voffset,
  input  logic [4:0]         blk1_hoffset,
  input  logic [4:0]         blk2_hoffset,
  input  logic [4:0]         blk3_hoffset,
  input  logic [4:0]         blk4_hoffset,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  input  logic               rd_data,
  output logic               busy,
  output logic               done,
  output logic               collide,
  output logic               oob,
  output logic [3:0]         hit_mask
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] org_row_q, org_row_d, org_col_q, org_col_d;
  logic [OFF_W-1:0]   voff_q [4], voff_d [4], hoff_q [4], hoff_d [4];
  logic [COORD_W-1:0] cell_row_q [4], cell_row_d [4], cell_col_q [4], cell_col_d [4];
  logic [3:0]         rd_ok_q, rd_ok_d;
  logic               rd_pend_q, rd_pend_d;
  logic [1:0]         rd_idx_q, rd_idx_d;
  logic [3:0]         hit_mask_q, hit_mask_d;
  logic               oob_q, oob_d;

  logic [OFF_W-1:0]   voff_in [4], hoff_in [4];
  logic [COORD_W-1:0] calc_row [4], calc_col [4];
  logic [3:0]         calc_oob, calc_above;
  logic [1:0]         slot;
  logic               slot_vld;
  logic               sample_hit;

  assign voff_in[0] = blk1_voffset;
  assign voff_in[1] = blk2_voffset;
  assign voff_in[2] = blk3_voffset;
  assign voff_in[3] = blk4_voffset;
  assign hoff_in[0] = blk1_hoffset;
  assign hoff_in[1] = blk2_hoffset;
  assign hoff_in[2] = blk3_hoffset;
  assign hoff_in[3] = blk4_hoffset;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    tetron_abs_coord #(
      .BOARD_COLS (BOARD_COLS),
      .BOARD_ROWS (BOARD_ROWS)
    ) u_abs (
      .origin_row (org_row_q),
      .origin_col (org_col_q),
      .voff       (voff_q[k]),
      .hoff       (hoff_q[k]),
      .cell_row   (calc_row[k]),
      .cell_col   (calc_col[k]),
      .oob        (calc_oob[k]),
      .above      (calc_above[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    org_row_d  = org_row_q;
    org_col_d  = org_col_q;
    voff_d     = voff_q;
    hoff_d     = hoff_q;
    cell_row_d = cell_row_q;
    cell_col_d = cell_col_q;
    rd_ok_d    = rd_ok_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = rd_idx_q;
    hit_mask_d = hit_mask_q;
    oob_d      = oob_q;
    slot       = 2'd0;
    slot_vld   = 1'b0;

    // Response to the read issued last cycle.
    sample_hit = rd_pend_q & rd_data;
    if (sample_hit) hit_mask_d[rd_idx_q] = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          org_row_d  = origin_row;
          org_col_d  = origin_col;
          voff_d     = voff_in;
          hoff_d     = hoff_in;
          hit_mask_d = 4'b0000;
          oob_d      = 1'b0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        cell_row_d = calc_row;
        cell_col_d = calc_col;
        rd_ok_d    = ~(calc_oob | calc_above);
        hit_mask_d = calc_oob;
        oob_d      = |calc_oob;
`ifdef TETRON_CC_EARLY_EXIT_EN
        state_d    = (|calc_oob) ? ST_DONE : ST_READ1;
`else
        state_d    = ST_READ1;
`endif
      end
      ST_READ1: begin slot = 2'd0; slot_vld = 1'b1; state_d = ST_READ2; end
      ST_READ2: begin slot = 2'd1; slot_vld = 1'b1; state_d = ST_READ3; end
      ST_READ3: begin slot = 2'd2; slot_vld = 1'b1; state_d = ST_READ4; end
      ST_READ4: begin slot = 2'd3; slot_vld = 1'b1; state_d = ST_DRAIN; end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Skipped slots (out of bounds or above the top) still take their cycle.
    rd_en  = slot_vld & rd_ok_q[slot];
    rd_row = rd_en ? cell_row_q[slot] : '0;
    rd_col = rd_en ? cell_col_q[slot] : '0;
    if (rd_en) begin
      rd_pend_d = 1'b1;
      rd_idx_d  = slot;
    end

`ifdef TETRON_CC_EARLY_EXIT_EN
    // First occupied cell ends the check; a read issued this cycle is dropped.
    if (sample_hit) begin
      state_d   = ST_DONE;
      rd_pend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      hit_mask_q <= 4'b0000;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      hit_mask_q <= hit_mask_d;
      oob_q      <= oob_d;
    end
  end

  always_ff @(posedge clk) begin
    org_row_q  <= org_row_d;
    org_col_q  <= org_col_d;
    voff_q     <= voff_d;
    hoff_q     <= hoff_d;
    cell_row_q <= cell_row_d;
    cell_col_q <= cell_col_d;
    rd_ok_q    <= rd_ok_d;
    rd_idx_q   <= rd_idx_d;
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign hit_mask = hit_mask_q;
  assign oob      = oob_q;
  assign collide  = |hit_mask_q;

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Self-checking bench for tetron_collision_checker: directed placements,
// randomized placements against a board-level reference model, req hold and reset abort.
module tb_tetron_collision_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [4:0] origin_row = '0, origin_col = '0;
  logic [4:0] blk1_voffset = '0, blk2_voffset = '0, blk3_voffset = '0, blk4_voffset = '0;
  logic [4:0] blk1_hoffset = '0, blk2_hoffset = '0, blk3_hoffset = '0, blk4_hoffset = '0;
  logic       rd_en;
  logic [4:0] rd_row, rd_col;
  logic       rd_data = 1'b0;
  logic       busy, done, collide, oob;
  logic [3:0] hit_mask;

  int checks = 0;
  int failures = 0;
  int txn_id = 0;

  bit   occ [20][10];
  int   tv [4];
  int   th [4];
  int   orow, ocol;
  logic [3:0] ex_hit;
  logic ex_oob;
  int   ex_lat;
  bit   ex_rd [16];
  int   ex_r [16];
  int   ex_c [16];

  tetron_collision_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .origin_row   (origin_row),
    .origin_col   (origin_col),
    .blk1_voffset (blk1_voffset),
    .blk2_voffset (blk2_voffset),
    .blk3_voffset (blk3_voffset),
    .blk4_voffset (blk4_voffset),
    .blk1_hoffset (blk1_hoffset),
    .blk2_hoffset (blk2_hoffset),
    .blk3_hoffset (blk3_hoffset),
    .blk4_hoffset (blk4_hoffset),
    .rd_en        (rd_en),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .collide      (collide),
    .oob          (oob),
    .hit_mask     (hit_mask)
  );

  always #5 clk = ~clk;

  // Playfield RAM: one-cycle read latency.
  always @(posedge clk)
    rd_data <= (rd_en && rd_row < 20 && rd_col < 10) ? occ[rd_row][rd_col] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s txn=%0d observed=%0d expected=%0d", tag, txn_id, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        occ[r][c] = 1'b0;
  endtask

  task automatic set_rot0();
    tv = '{0, -1, 0, 1};
    th = '{0, -1, -1, 0};
  endtask

  task automatic drive_inputs(input int r, input int c);
    origin_row   = 5'(r);
    origin_col   = 5'(c);
    blk1_voffset = 5'(tv[0]);
    blk2_voffset = 5'(tv[1]);
    blk3_voffset = 5'(tv[2]);
    blk4_voffset = 5'(tv[3]);
    blk1_hoffset = 5'(th[0]);
    blk2_hoffset = 5'(th[1]);
    blk3_hoffset = 5'(th[2]);
    blk4_hoffset = 5'(th[3]);
  endtask

  task automatic scramble_inputs();
    origin_row   = 5'($urandom);
    origin_col   = 5'($urandom);
    blk1_voffset = 5'($urandom);
    blk2_voffset = 5'($urandom);
    blk3_voffset = 5'($urandom);
    blk4_voffset = 5'($urandom);
    blk1_hoffset = 5'($urandom);
    blk2_hoffset = 5'($urandom);
    blk3_hoffset = 5'($urandom);
    blk4_hoffset = 5'($urandom);
  endtask

  // Reference: cycle offsets from the accept cycle T for reads, done and results.
  task automatic model();
    int r [4];
    int c [4];
    bit bo [4];
    bit legal [4];
    bit stop;
    ex_hit = 4'b0000;
    ex_oob = 1'b0;
    ex_lat = 7;
    stop   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ex_rd[i] = 1'b0;
      ex_r[i]  = 0;
      ex_c[i]  = 0;
    end
    for (int k = 0; k < 4; k++) begin
      r[k]     = orow + tv[k];
      c[k]     = ocol + th[k];
      bo[k]    = (c[k] < 0) || (c[k] >= 10) || (r[k] >= 20);
      legal[k] = !bo[k] && (r[k] >= 0);
      if (bo[k]) ex_oob = 1'b1;
    end
`ifdef TETRON_CC_EARLY_EXIT_EN
    if (ex_oob) begin
      ex_lat = 2;
      for (int k = 0; k < 4; k++) ex_hit[k] = bo[k];
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!stop && legal[k]) begin
          ex_rd[2+k] = 1'b1;
          ex_r[2+k]  = r[k];
          ex_c[2+k]  = c[k];
          if (occ[r[k]][c[k]]) begin
            ex_hit[k] = 1'b1;
            ex_lat    = 4 + k;
            stop      = 1'b1;
            if (k < 3 && legal[k+1]) begin
              ex_rd[3+k] = 1'b1;
              ex_r[3+k]  = r[k+1];
              ex_c[3+k]  = c[k+1];
            end
          end
        end
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      ex_hit[k] = bo[k];
      if (legal[k]) begin
        ex_rd[2+k] = 1'b1;
        ex_r[2+k]  = r[k];
        ex_c[2+k]  = c[k];
        if (occ[r[k]][c[k]]) ex_hit[k] = 1'b1;
      end
    end
`endif
  endtask

  task automatic run_txn(input int r, input int c);
    txn_id++;
    orow = r;
    ocol = c;
    model();
    @(negedge clk);
    chk("pre_busy", busy, 0);
    drive_inputs(r, c);
    req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("clr_mask", hit_mask, 0);
        chk("clr_oob", oob, 0);
        req = 1'b0;
        scramble_inputs();
      end
      chk("busy", busy, 32'(i < ex_lat));
      chk("done", done, 32'(i == ex_lat));
      chk("rd_en", rd_en, 32'(ex_rd[i]));
      if (ex_rd[i]) begin
        chk("rd_row", rd_row, ex_r[i]);
        chk("rd_col", rd_col, ex_c[i]);
      end
      if (i >= ex_lat) begin
        chk("hit_mask", hit_mask, ex_hit);
        chk("oob", oob, ex_oob);
        chk("collide", collide, 32'(|ex_hit));
      end
    end
  endtask

  function automatic int rand_off(input bit wide);
    logic signed [4:0] s;
    if (wide) s = 5'($urandom);
    else      s = 5'($urandom_range(0, 4) - 2);
    return int'(s);
  endfunction

  initial begin
    int ndone, first, second;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_row", rd_row, 0);
    chk("rst_rd_col", rd_col, 0);
    chk("rst_collide", collide, 0);
    chk("rst_oob", oob, 0);
    chk("rst_hit_mask", hit_mask, 0);
    rst_n = 1'b1;

    // Empty board, rotation 0 at (5,4)
    clear_board();
    set_rot0();
    run_txn(5, 4);

    // Cell (6,4) occupied
    occ[6][4] = 1'b1;
    run_txn(5, 4);
    clear_board();

    // Left edge violation
    tv = '{0, 0, 1, 2};
    th = '{0, -1, 0, 0};
    run_txn(5, 0);

    // Bottom edge violation
    set_rot0();
    run_txn(19, 4);

    // Above-top block is legal and unread
    occ[0][4] = 1'b1;
    run_txn(0, 4);
    clear_board();

    // First block occupied
    occ[5][4] = 1'b1;
    run_txn(5, 4);
    clear_board();

    // Randomized placements on random boards
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++)
          occ[r][c] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        tv[k] = rand_off(n % 5 == 4);
        th[k] = rand_off(n % 5 == 4);
      end
      run_txn(int'($urandom_range(0, 21)), int'($urandom_range(0, 11)));
    end

    // req held for 12 cycles: accepts at T and T+8 only
    txn_id++;
    clear_board();
    set_rot0();
    orow = 5;
    ocol = 4;
    model();
    ndone  = 0;
    first  = -1;
    second = -1;
    @(negedge clk);
    drive_inputs(5, 4);
    req = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 12) req = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("held_ndone", ndone, 2);
    chk("held_first", first, ex_lat);
    chk("held_second", second, 8 + ex_lat);

    // Reset asserted mid-check aborts it
    txn_id++;
    occ[6][4] = 1'b1;
    @(negedge clk);
    drive_inputs(5, 4);
    req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_mask", hit_mask, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    clear_board();

    // Normal operation after the abort
    run_txn(5, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
